// File: rtl/jz_sopc_bus_pkg.sv
// Shared definitions for the SOPC data-side interconnect: FSM encoding,
// completion status codes and the default memory map used by the link map.
package jz_sopc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } bus_state_t;

  localparam logic BUS_OK  = 1'b0;
  localparam logic BUS_ERR = 1'b1;

  // Slice i is slave i: RAM, LED/switch GPIO, timer, expansion.
  localparam logic [127:0] DEFAULT_BASE = {32'h1000_0000, 32'h0800_0000,
                                           32'h0400_0000, 32'h0000_0000};
  localparam logic [127:0] DEFAULT_MASK = {32'hFFFF_F000, 32'hFFFF_FF00,
                                           32'hFFFF_FF00, 32'hFFFF_0000};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jz_bus_decoder.sv
// Combinational address decoder: masked compare per slave, lowest index wins
// on overlapping windows.
module jz_bus_decoder
  import jz_sopc_bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int IDX_W    = idx_width(N_SLAVES)
) (
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [N_SLAVES*ADDR_W-1:0] slave_base,
  input  logic [N_SLAVES*ADDR_W-1:0] slave_mask,
  output logic [N_SLAVES-1:0]        hit,
  output logic [IDX_W-1:0]           idx,
  output logic                       miss
);

  logic [N_SLAVES-1:0] raw_hit;

  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_cmp
      assign raw_hit[gi] = (m_addr & slave_mask[gi*ADDR_W +: ADDR_W])
                           == slave_base[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  always_comb begin
    idx  = '0;
    hit  = '0;
    miss = ~|raw_hit;
    // Scan downwards so the last assignment is the lowest matching index.
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (raw_hit[i]) idx = IDX_W'(i);
    end
    if (!miss) hit[idx] = 1'b1;
  end

endmodule

// File: rtl/jz_sopc_bus.sv
// Data-side interconnect: decodes the core's request onto one of N slaves,
// waits for its ack with a timeout, and returns data plus an error flag.
module jz_sopc_bus
  import jz_sopc_bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEFAULT_BASE,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEFAULT_MASK,
  parameter int TIMEOUT  = 255,
  parameter int TO_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_ce,
  input  logic                       m_we,
  input  logic [DATA_W/8-1:0]        m_sel,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic [N_SLAVES-1:0]        s_ce,
  output logic                       s_we,
  output logic [DATA_W/8-1:0]        s_sel,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_ack,
  output logic [7:0]                 err_count
);

  localparam int IDX_W = idx_width(N_SLAVES);

  bus_state_t          state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                we_reg, we_next;
  logic [DATA_W/8-1:0] sel_reg, sel_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                err_reg, err_next;
  logic [TO_W-1:0]     cnt_reg, cnt_next;
  logic [7:0]          err_count_reg, err_count_next;

  logic [N_SLAVES-1:0] dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_miss;
  logic [DATA_W-1:0]   slv_rdata [N_SLAVES];

  jz_bus_decoder #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W)
  ) u_decoder (
    .m_addr     (m_addr),
    .slave_base (SLAVE_BASE),
    .slave_mask (SLAVE_MASK),
    .hit        (dec_hit),
    .idx        (dec_idx),
    .miss       (dec_miss)
  );

  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_rdata
      assign slv_rdata[gi] = s_rdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      err_reg       <= BUS_OK;
      cnt_reg       <= '0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      cnt_reg       <= cnt_next;
      err_count_reg <= err_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    we_next        = we_reg;
    sel_next       = sel_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    cnt_next       = cnt_reg;
    err_count_next = err_count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (m_ce) begin
          rdata_next = '0;
          if (dec_miss) begin
            err_next   = BUS_ERR;
            state_next = ST_DONE;
          end else begin
            idx_next   = dec_idx;
            we_next    = m_we;
            sel_next   = m_sel;
            addr_next  = m_addr;
            wdata_next = m_wdata;
            cnt_next   = '0;
            err_next   = BUS_OK;
            state_next = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (s_ack[idx_reg]) begin
          rdata_next = we_reg ? '0 : slv_rdata[idx_reg];
          err_next   = BUS_OK;
          state_next = ST_DONE;
        end else if (cnt_reg == TO_W'(TIMEOUT - 1)) begin
          rdata_next = '0;
          err_next   = BUS_ERR;
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        if (err_reg && err_count_reg != 8'hFF) err_count_next = err_count_reg + 8'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shared slave-side buses keep their last latched value; only ce/we are qualified.
  assign s_ce      = (state_reg == ST_ACCESS) ? (N_SLAVES'(1) << idx_reg) : '0;
  assign s_we      = (state_reg == ST_ACCESS) && we_reg;
  assign s_sel     = sel_reg;
  assign s_addr    = addr_reg;
  assign s_wdata   = wdata_reg;
  assign m_ready   = (state_reg == ST_DONE);
  assign m_err     = (state_reg == ST_DONE) && err_reg;
  assign m_rdata   = (state_reg == ST_DONE) ? rdata_reg : '0;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_jz_sopc_bus.sv
// Directed bench for jz_sopc_bus: reads, writes with wait states, unmapped,
// timeout, reset abort, back-to-back and error-counter saturation.
module tb_jz_sopc_bus;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_ce;
  logic         m_we;
  logic [3:0]   m_sel;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [31:0]  m_rdata;
  logic         m_ready;
  logic         m_err;
  logic [3:0]   s_ce;
  logic         s_we;
  logic [3:0]   s_sel;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ack;
  logic [7:0]   err_count;

  int n_checks = 0;
  int n_errors = 0;

  jz_sopc_bus dut (
    .clk       (clk),
    .rst       (rst),
    .m_ce      (m_ce),
    .m_we      (m_we),
    .m_sel     (m_sel),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .s_ce      (s_ce),
    .s_we      (s_we),
    .s_sel     (s_sel),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ack     (s_ack),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata);
    m_ce    = 1'b1;
    m_we    = we;
    m_sel   = sel;
    m_addr  = addr;
    m_wdata = wdata;
  endtask

  initial begin
    logic early;
    rst     = 1'b0;
    m_ce    = 1'b0;
    m_we    = 1'b0;
    m_sel   = 4'h0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    s_rdata = '0;
    s_ack   = 4'h0;
    repeat (3) tick();
    check("rst_s_ce", s_ce, 4'h0);
    check("rst_m_ready", m_ready, 1'b0);
    check("rst_m_rdata", m_rdata, 32'h0);
    check("rst_err_count", err_count, 8'h0);
    check("rst_s_addr", s_addr, 32'h0);
    rst = 1'b1;
    tick();

    // Zero-wait read from slave0.
    s_rdata[31:0] = 32'hDEAD_BEEF;
    s_ack = 4'b0001;
    request(1'b0, 4'hF, 32'h0000_0010, 32'h0);
    tick();
    check("rd0_s_ce", s_ce, 4'b0001);
    check("rd0_ready_c1", m_ready, 1'b0);
    tick();
    check("rd0_ready", m_ready, 1'b1);
    check("rd0_rdata", m_rdata, 32'hDEAD_BEEF);
    check("rd0_err", m_err, 1'b0);
    m_ce  = 1'b0;
    s_ack = 4'b0000;
    tick();
    check("rd0_ready_gone", m_ready, 1'b0);
    check("idle_s_addr_held", s_addr, 32'h0000_0010);

    // Write to slave1 with three wait cycles; ack in the fourth ACCESS cycle.
    s_rdata[63:32] = 32'hCAFE_F00D;
    request(1'b1, 4'b0011, 32'h0400_0004, 32'h1234_5678);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("wr_s_ce_c%0d", c), s_ce, 4'b0010);
      check($sformatf("wr_s_we_c%0d", c), s_we, 1'b1);
      check($sformatf("wr_s_sel_c%0d", c), s_sel, 4'b0011);
      check($sformatf("wr_ready_c%0d", c), m_ready, 1'b0);
      if (c == 4) s_ack = 4'b0010;
    end
    check("wr_s_wdata", s_wdata, 32'h1234_5678);
    tick();
    check("wr_ready_c5", m_ready, 1'b1);
    check("wr_rdata_zero", m_rdata, 32'h0);
    check("wr_err", m_err, 1'b0);
    check("wr_s_we_gated", s_we, 1'b0);
    m_ce  = 1'b0;
    s_ack = 4'b0000;
    tick();

    // Unmapped address.
    request(1'b0, 4'hF, 32'hFFFF_0000, 32'h0);
    tick();
    check("um_s_ce", s_ce, 4'h0);
    check("um_ready", m_ready, 1'b1);
    check("um_err", m_err, 1'b1);
    check("um_rdata", m_rdata, 32'h0);
    m_ce = 1'b0;
    tick();
    check("um_err_count", err_count, 8'd1);

    // Timeout on slave3 with stray acks from the others.
    s_rdata[127:96] = 32'h5555_AAAA;
    s_ack = 4'b0111;
    request(1'b0, 4'hF, 32'h1000_0000, 32'h0);
    early = 1'b0;
    for (int c = 1; c <= 255; c++) begin
      tick();
      if (m_ready) early = 1'b1;
      if (c == 1) check("to_s_ce_first", s_ce, 4'b1000);
      if (c == 255) check("to_s_ce_last", s_ce, 4'b1000);
    end
    check("to_no_early_ready", early, 1'b0);
    tick();
    check("to_ready_256", m_ready, 1'b1);
    check("to_err", m_err, 1'b1);
    check("to_rdata", m_rdata, 32'h0);
    m_ce  = 1'b0;
    s_ack = 4'b0000;
    tick();
    check("to_err_count", err_count, 8'd2);

    // Reset during the second wait cycle of a slave2 read.
    request(1'b0, 4'hF, 32'h0800_0000, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rstmid_s_ce", s_ce, 4'h0);
    check("rstmid_ready", m_ready, 1'b0);
    check("rstmid_err_count", err_count, 8'd0);
    check("rstmid_s_addr", s_addr, 32'h0);
    rst  = 1'b1;
    m_ce = 1'b0;
    tick();
    check("rstmid_no_ready", m_ready, 1'b0);
    s_rdata[95:64] = 32'h0BAD_F00D;
    s_ack = 4'b0100;
    request(1'b0, 4'hF, 32'h0800_0000, 32'h0);
    tick();
    check("post_rst_s_ce", s_ce, 4'b0100);
    tick();
    check("post_rst_ready", m_ready, 1'b1);
    check("post_rst_rdata", m_rdata, 32'h0BAD_F00D);
    m_ce  = 1'b0;
    s_ack = 4'b0000;
    tick();

    // Back-to-back reads with m_ce held: slave0 then slave2.
    s_rdata[31:0]  = 32'h1111_1111;
    s_rdata[95:64] = 32'h2222_2222;
    s_ack = 4'b0101;
    request(1'b0, 4'hF, 32'h0000_0020, 32'h0);
    tick();
    tick();
    check("b2b_ready_a", m_ready, 1'b1);
    check("b2b_rdata_a", m_rdata, 32'h1111_1111);
    m_addr = 32'h0800_0004;
    tick();
    check("b2b_gap", m_ready, 1'b0);
    tick();
    check("b2b_s_ce_b", s_ce, 4'b0100);
    tick();
    check("b2b_ready_b", m_ready, 1'b1);
    check("b2b_rdata_b", m_rdata, 32'h2222_2222);
    m_ce  = 1'b0;
    s_ack = 4'b0000;
    tick();

    // Saturation: continuous unmapped requests, each taking two cycles.
    request(1'b0, 4'hF, 32'hFFFF_0000, 32'h0);
    repeat (600) tick();
    m_ce = 1'b0;
    repeat (2) tick();
    check("err_count_sat", err_count, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
